// File: rtl/key_schedule_ctrl.sv
`default_nettype none
// =============================================================================
// key_schedule_ctrl : iterative AES-128 key schedule feeding a round-key file
// Rev 1.0
// =============================================================================
module key_schedule_ctrl #(
   parameter int NK = 4,
   parameter int NR = NK + 6
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic         busy,
   output logic         keys_valid,
   output logic         done,
   input  logic         rd_en,
   input  logic [3:0]   rd_round,
   output logic [127:0] rd_key,
   output logic         rd_valid,
   output logic         rd_err
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_EXPAND = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   localparam logic [3:0] LAST = 4'(NR);

   state_t         state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic           done_q, done_d;
   logic [127:0]   rk_q [0:NR];
   logic [127:0]   rk_d [0:NR];
   logic [127:0]   rd_key_q, rd_key_d;
   logic           rd_valid_q, rd_valid_d;
   logic           rd_err_q, rd_err_d;
   logic [127:0]   next_rk;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box as GF(2^8) inverse (x^254, so 0 maps to 0) followed by the affine map
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] x2, x3, x6, x12, x15, t, b;
      x2  = gf_mul(x, x);
      x3  = gf_mul(x2, x);
      x6  = gf_mul(x3, x3);
      x12 = gf_mul(x6, x6);
      x15 = gf_mul(x12, x3);
      t   = x15;
      for (int i = 0; i < 4; i++) t = gf_mul(t, t);
      b   = gf_mul(gf_mul(t, x12), x2);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] rnd);
      case (rnd)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // Key bytes are big-endian: byte 0 of the key occupies bits [127:120]
   function automatic logic [127:0] key_expansion(input logic [127:0] prev,
                                                  input logic [3:0]   rnd);
      logic [31:0] w0, w1, w2, w3, rot, t, n0, n1, n2, n3;
      w0  = prev[127:96];
      w1  = prev[95:64];
      w2  = prev[63:32];
      w3  = prev[31:0];
      rot = {w3[23:0], w3[31:24]};
      t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
            ^ {rcon(rnd), 24'h000000};
      n0  = w0 ^ t;
      n1  = w1 ^ n0;
      n2  = w2 ^ n1;
      n3  = w3 ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   assign next_rk = key_expansion(rk_q[cnt_q - 4'd1], cnt_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rk_d    = rk_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               rk_d[0] = key_in;
               cnt_d   = 4'd1;
               state_d = S_EXPAND;
            end
         end
         S_EXPAND: begin
            rk_d[cnt_q] = next_rk;
            if (cnt_q == LAST) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Reads see the registers before this edge, so a read alongside a restart returns old keys
   always_comb begin
      rd_key_d   = rd_key_q;
      rd_valid_d = 1'b0;
      rd_err_d   = 1'b0;
      if (rd_en) begin
         if ((state_q == S_DONE) && (rd_round <= LAST)) begin
            rd_key_d   = rk_q[rd_round];
            rd_valid_d = 1'b1;
         end else begin
            rd_key_d = '0;
            rd_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         done_q     <= 1'b0;
         rk_q       <= '{default: '0};
         rd_key_q   <= '0;
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
         rk_q       <= rk_d;
         rd_key_q   <= rd_key_d;
         rd_valid_q <= rd_valid_d;
         rd_err_q   <= rd_err_d;
      end
   end

   assign busy       = (state_q == S_EXPAND);
   assign keys_valid = (state_q == S_DONE);
   assign done       = done_q;
   assign rd_key     = rd_key_q;
   assign rd_valid   = rd_valid_q;
   assign rd_err     = rd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_key_schedule_ctrl.sv
`default_nettype none
// =============================================================================
// tb_key_schedule_ctrl : directed scoreboard bench for key_schedule_ctrl
// Rev 1.0
// =============================================================================
module tb_key_schedule_ctrl;

   localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         start = 1'b0;
   logic [127:0] key_in = '0;
   logic         rd_en = 1'b0;
   logic [3:0]   rd_round = 4'd0;
   logic         busy, keys_valid, done, rd_valid, rd_err;
   logic [127:0] rd_key;

   typedef struct {
      logic         v;
      logic         e;
      logic [127:0] k;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   key_schedule_ctrl dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .key_in     (key_in),
      .busy       (busy),
      .keys_valid (keys_valid),
      .done       (done),
      .rd_en      (rd_en),
      .rd_round   (rd_round),
      .rd_key     (rd_key),
      .rd_valid   (rd_valid),
      .rd_err     (rd_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_rd(input logic [3:0] r, input logic ok, input logic [127:0] k);
      exp_t x;
      x.v = ok;
      x.e = ~ok;
      x.k = ok ? k : '0;
      sb.push_back(x);
      rd_en    = 1'b1;
      rd_round = r;
      tick();
      rd_en    = 1'b0;
   endtask

   task automatic do_start(input logic [127:0] key);
      start  = 1'b1;
      key_in = key;
      tick();
      start  = 1'b0;
      key_in = '1;
   endtask

   // Entered right after the start edge; cycle i is the i-th cycle after that edge
   task automatic watch_expand(output int nb, output int nd, output int kv, output int excl);
      nb = 0; nd = 0; kv = 0; excl = 0;
      for (int i = 1; i <= 13; i++) begin
         if (busy) nb++;
         if (done) nd++;
         if (keys_valid && kv == 0) kv = i;
         if (busy && keys_valid) excl++;
         tick();
      end
   endtask

   task automatic wait_kv();
      for (int i = 0; i < 20 && !keys_valid; i++) tick();
      chk("kv_timeout", keys_valid, 1);
   endtask

   always @(negedge clk) begin
      if (reset_n && (rd_valid || rd_err)) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rd_unexpected: got valid=%b err=%b expected no response", rd_valid, rd_err);
         end else begin
            exp_t x;
            x = sb.pop_front();
            chk("rd_valid", rd_valid, x.v);
            chk("rd_err", rd_err, x.e);
            chk("rd_key", rd_key, x.k);
         end
      end
   end

   initial begin
      int nb, nd, kv, ex;

      repeat (3) tick();
      chk("rst_busy", busy, 0);
      chk("rst_keys_valid", keys_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_key", rd_key, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_err", rd_err, 0);
      reset_n = 1'b1;
      tick();

      // Test 1: FIPS-197 key expansion timing
      do_start(K1);
      watch_expand(nb, nd, kv, ex);
      chk("t1_busy_cycles", nb, 10);
      chk("t1_done_pulses", nd, 1);
      chk("t1_kv_cycle", kv, 11);
      chk("t1_exclusive", ex, 0);

      // Tests 2 and 3: valid and out-of-range reads
      issue_rd(4'd0, 1'b1, K1);
      issue_rd(4'd1, 1'b1, K1_R1);
      issue_rd(4'd10, 1'b1, K1_R10);
      issue_rd(4'd11, 1'b0, '0);
      issue_rd(4'd15, 1'b0, '0);

      // Test 4: second start mid-expansion is ignored
      do_start(K1);
      repeat (3) tick();
      chk("t4_busy", busy, 1);
      start  = 1'b1;
      key_in = K2;
      issue_rd(4'd0, 1'b0, '0);
      start  = 1'b0;
      key_in = '1;
      wait_kv();
      issue_rd(4'd10, 1'b1, K1_R10);
      issue_rd(4'd0, 1'b1, K1);

      // Test 5: restart from DONE, read on the same edge served from old keys
      start  = 1'b1;
      key_in = K2;
      issue_rd(4'd10, 1'b1, K1_R10);
      start  = 1'b0;
      key_in = '1;
      chk("t5_kv_drop", keys_valid, 0);
      chk("t5_busy", busy, 1);
      watch_expand(nb, nd, kv, ex);
      chk("t5_busy_cycles", nb, 10);
      chk("t5_done_pulses", nd, 1);
      chk("t5_kv_cycle", kv, 11);
      issue_rd(4'd10, 1'b1, K2_R10);
      issue_rd(4'd0, 1'b1, K2);

      // Test 6: asynchronous reset mid-expansion
      do_start(K1);
      repeat (4) tick();
      chk("t6_busy_before", busy, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6_busy", busy, 0);
      chk("t6_keys_valid", keys_valid, 0);
      chk("t6_done", done, 0);
      chk("t6_rd_key", rd_key, 0);
      chk("t6_rd_valid", rd_valid, 0);
      chk("t6_rd_err", rd_err, 0);
      tick();
      reset_n = 1'b1;
      repeat (2) tick();
      chk("t6_idle_busy", busy, 0);
      chk("t6_idle_kv", keys_valid, 0);
      issue_rd(4'd0, 1'b0, '0);

      repeat (3) tick();
      chk("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
